fifo_rd_drain: RTL and testbench

Read-side drain stage sitting directly downstream of asy_fifo, entirely in the rd_clk domain. It watches fifo_empty, issues fifo_rd_en, captures the one-cycle-latency fifo_rd_data into a 2-entry output buffer, and presents the words on a valid/ready stream. An enable input lets the consumer gate reads for low-power idle. A gated stop drains in-flight data cleanly; no words are lost or duplicated.

---
 rtl/fifo_rd_drain.sv | 97 +++++++++
 tb/tb_fifo_rd_drain.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side drain stage behind asy_fifo: fetches words into a 2-entry buffer and
// presents them on a valid/ready stream, draining in-flight reads cleanly when en drops.
module fifo_rd_drain #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             pend_q, pend_d;
  logic             head_q, head_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             pop;
  logic             tail;
  logic [1:0]       committed;

  always_comb begin
    pop        = (occ_q != 2'd0) && out_ready;
    // Slots already owned by buffered or in-flight words once this cycle's pop retires.
    committed  = occ_q + {1'b0, pend_q} - {1'b0, pop};
    fifo_rd_en = !rd_rst && (state_q == RUN) && !fifo_empty && (committed < 2'd2);
    tail       = head_q ^ occ_q[0];

    state_d    = state_q;
    occ_d      = occ_q;
    pend_d     = fifo_rd_en;
    head_d     = head_q;
    buf_d      = buf_q;
    word_cnt_d = word_cnt_q;

    if (pend_q) buf_d[tail] = fifo_rd_data;
    if (pop) head_d = ~head_q;

    case ({pend_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (cnt_clr)  word_cnt_d = '0;
    else if (pop) word_cnt_d = word_cnt_q + 1'b1;

    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                               state_d = RUN;
        else if (occ_q == 2'd0 && !pend_q)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      pend_q     <= 1'b0;
      head_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      word_cnt_q <= '0;
    end else begin
      assert (occ_d != 2'd3);
      state_q    <= state_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      head_q     <= head_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      word_cnt_q <= word_cnt_d;
    end
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_q[head_q];
  assign busy      = (state_q != IDLE);
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain with a one-cycle-latency FIFO model upstream.
// The counter is built 8 bits wide so the wrap case is reachable in a short run.
module tb_fifo_rd_drain;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             rd_clk;
  logic             rd_rst;
  logic             en;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic             cnt_clr;
  logic [CNT_W-1:0] word_cnt;

  logic [7:0] mem [0:511];
  int         wr_ptr;
  int         rd_ptr;
  logic       tb_flush;

  logic [7:0] out_log [0:511];
  int         out_cyc [0:511];
  int         out_n;
  int         cyc;

  int vectors;
  int miscompares;

  fifo_rd_drain #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .cnt_clr      (cnt_clr),
    .word_cnt     (word_cnt)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  assign fifo_empty = (rd_ptr == wr_ptr);

  initial begin
    rd_ptr       = 0;
    fifo_rd_data = '0;
    out_n        = 0;
    cyc          = 0;
  end

  always @(posedge rd_clk) begin
    if (tb_flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (!rd_rst && out_valid && out_ready) begin
      out_log[out_n] <= out_data;
      out_cyc[out_n] <= cyc;
      out_n          <= out_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int base_rd;
    int base_out;
    int c0;
    int idle_seen;

    vectors = 0; miscompares = 0;
    wr_ptr = 0; tb_flush = 1'b0;
    rd_rst = 1'b1; en = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;

    // Reset state
    tick(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    rd_rst = 1'b0;
    tick(1);
    chk("idle_rd_en", fifo_rd_en, 0);
    chk("idle_busy", busy, 0);

    // Streaming: 8 words at full rate
    base_rd = rd_ptr; base_out = out_n;
    for (int i = 0; i < 8; i++) push(8'h03 + 8'(i * 14));
    en = 1'b1; out_ready = 1'b1;
    tick(1);
    c0 = cyc;
    chk("stream_busy", busy, 1);
    chk("stream_rd_en", fifo_rd_en, 1);
    tick(13);
    chk("stream_nout", out_n - base_out, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("stream_word%0d", i), out_log[base_out + i], 8'h03 + 8'(i * 14));
    chk("stream_latency", out_cyc[base_out] - c0, 2);
    chk("stream_rate", out_cyc[base_out + 7] - out_cyc[base_out], 7);
    chk("stream_cnt", word_cnt, 8);
    chk("stream_reads", rd_ptr - base_rd, 8);
    chk("stream_rd_en_empty", fifo_rd_en, 0);
    chk("stream_valid_end", out_valid, 0);
    chk("stream_busy_end", busy, 1);

    // Backpressure: 5 words, consumer stalled
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clr_cnt", word_cnt, 0);
    out_ready = 1'b0;
    base_rd = rd_ptr; base_out = out_n;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    tick(6);
    chk("bp_reads", rd_ptr - base_rd, 2);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'hA0);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_nout", out_n - base_out, 0);
    out_ready = 1'b1;
    tick(10);
    chk("bp_nout_rel", out_n - base_out, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_word%0d", i), out_log[base_out + i], 8'hA0 + 8'(i));
    chk("bp_reads_rel", rd_ptr - base_rd, 5);
    chk("bp_cnt", word_cnt, 5);

    // Drain stop: en drops in the same cycle as a read
    base_rd = rd_ptr; base_out = out_n;
    push(8'hC0); push(8'hC1); push(8'hC2);
    tick(1);
    chk("drain_rd_en_pre", fifo_rd_en, 1);
    en = 1'b0;
    tick(1);
    chk("drain_busy0", busy, 1);
    chk("drain_rd_en0", fifo_rd_en, 0);
    tick(2);
    chk("drain_busy1", busy, 1);
    chk("drain_valid1", out_valid, 0);
    chk("drain_rd_en1", fifo_rd_en, 0);
    tick(1);
    chk("drain_idle", busy, 0);
    tick(3);
    chk("drain_reads", rd_ptr - base_rd, 2);
    chk("drain_nout", out_n - base_out, 2);
    chk("drain_word0", out_log[base_out], 8'hC0);
    chk("drain_word1", out_log[base_out + 1], 8'hC1);
    chk("drain_rd_en_idle", fifo_rd_en, 0);

    // Re-enable during DRAIN
    base_rd = rd_ptr; base_out = out_n; idle_seen = 0;
    push(8'hD0); push(8'hD1); push(8'hD2);
    en = 1'b1; out_ready = 1'b0;
    tick(6);
    chk("reen_reads", rd_ptr - base_rd, 2);
    chk("reen_data", out_data, 8'hC2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (!busy) idle_seen++;
    end
    chk("reen_drain_rd_en", fifo_rd_en, 0);
    en = 1'b1;
    tick(1);
    if (!busy) idle_seen++;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!busy) idle_seen++;
    end
    chk("reen_no_idle", idle_seen, 0);
    chk("reen_nout", out_n - base_out, 4);
    chk("reen_word0", out_log[base_out], 8'hC2);
    chk("reen_word1", out_log[base_out + 1], 8'hD0);
    chk("reen_word2", out_log[base_out + 2], 8'hD1);
    chk("reen_word3", out_log[base_out + 3], 8'hD2);

    // Counter wrap and clear priority
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    base_out = out_n;
    for (int i = 0; i < 255; i++) push(8'(i));
    tick(262);
    chk("wrap_nout", out_n - base_out, 255);
    chk("wrap_last", out_log[base_out + 254], 8'hFE);
    chk("wrap_cnt_max", word_cnt, 8'hFF);
    push(8'h5A);
    tick(5);
    chk("wrap_cnt_zero", word_cnt, 0);
    chk("wrap_word", out_log[base_out + 255], 8'h5A);
    push(8'hE0); push(8'hE1); push(8'hE2);
    tick(6);
    chk("cnt_three", word_cnt, 3);
    out_ready = 1'b0;
    push(8'hF7);
    tick(4);
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, 8'hF7);
    chk("hold_cnt", word_cnt, 3);
    base_out = out_n;
    cnt_clr = 1'b1; out_ready = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clr_pop_cnt", word_cnt, 0);
    chk("clr_pop_nout", out_n - base_out, 1);
    chk("clr_pop_word", out_log[base_out], 8'hF7);

    // Reset mid-stream with a full buffer
    push(8'h21); push(8'h22);
    tick(5);
    out_ready = 1'b0;
    base_rd = rd_ptr;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    tick(6);
    chk("mid_cnt", word_cnt, 2);
    chk("mid_valid", out_valid, 1);
    chk("mid_data", out_data, 8'h31);
    chk("mid_reads", rd_ptr - base_rd, 2);
    rd_rst = 1'b1; tb_flush = 1'b1;
    tick(2);
    rd_rst = 1'b0; tb_flush = 1'b0; en = 1'b0;
    tick(1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", word_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_data", out_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
